// File: rtl/song_sequencer_if.sv
// Song-ROM read port and note-dispatch bus between the sequencer (master) and
// the ROM / note-player bank (slave).
interface song_sequencer_if #(
  parameter int SONG_BITS  = 2,
  parameter int ENTRY_BITS = 6,
  parameter int NUM_VOICES = 3
);
  localparam int ADDR_W  = SONG_BITS + ENTRY_BITS;
  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [ADDR_W-1:0]  rom_addr;
  logic [15:0]        rom_dout;
  logic               note_load;
  logic [VOICE_W-1:0] note_voice;
  logic [5:0]         note_out;
  logic [5:0]         dur_out;
  logic [2:0]         meta_out;

  modport master (
    output rom_addr, note_load, note_voice, note_out, dur_out, meta_out,
    input  rom_dout
  );

  modport slave (
    input  rom_addr, note_load, note_voice, note_out, dur_out, meta_out,
    output rom_dout
  );
endinterface

// File: rtl/song_sequencer.sv
// Steps one song through the song ROM, dispatching notes round-robin to voices
// on a beat grid. Define SONG_SEQUENCER_LOOP_EN to replay the song endlessly.
module song_sequencer #(
  parameter int NUM_VOICES = 3,
  parameter int SONG_BITS  = 2,
  parameter int ENTRY_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song,
  input  logic                 beat,
  song_sequencer_if.master     bus,
  output logic                 song_done,
  output logic                 busy
);

  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [ENTRY_BITS-1:0] LAST_IDX   = '1;
  localparam logic [VOICE_W-1:0]    LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

`ifdef SONG_SEQUENCER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [SONG_BITS-1:0]   song_l;
  logic [ENTRY_BITS-1:0]  index;
  logic [ENTRY_BITS-1:0]  index_nx;
  logic [VOICE_W-1:0]     vptr;
  logic [5:0]             cnt;
  logic                   armed;
  logic                   at_last;

  logic                   e_adv;
  logic [5:0]             e_note;
  logic [5:0]             e_dur;
  logic [2:0]             e_meta;

  assign e_adv    = bus.rom_dout[15];
  assign e_note   = bus.rom_dout[14:9];
  assign e_dur    = bus.rom_dout[8:3];
  assign e_meta   = bus.rom_dout[2:0];
  assign index_nx = index + 1'b1;
  assign at_last  = (index == LAST_IDX);
  assign busy     = (state != S_IDLE);

  function automatic logic [VOICE_W-1:0] next_voice(input logic [VOICE_W-1:0] v);
    return (v == LAST_VOICE) ? '0 : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      song_l         <= '0;
      index          <= '0;
      vptr           <= '0;
      cnt            <= '0;
      armed          <= 1'b1;
      song_done      <= 1'b0;
      bus.rom_addr   <= '0;
      bus.note_load  <= 1'b0;
      bus.note_voice <= '0;
      bus.note_out   <= '0;
      bus.dur_out    <= '0;
      bus.meta_out   <= '0;
    end else begin
      bus.note_load <= 1'b0;
      song_done     <= 1'b0;
      case (state)
        S_IDLE: begin
          index          <= '0;
          vptr           <= '0;
          cnt            <= '0;
          bus.note_voice <= '0;
          bus.note_out   <= '0;
          bus.dur_out    <= '0;
          bus.meta_out   <= '0;
          // A finished song leaves armed low so a held play does not restart it.
          if (!play) begin
            armed <= 1'b1;
          end else if (armed) begin
            song_l       <= song;
            bus.rom_addr <= {song, {ENTRY_BITS{1'b0}}};
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (play) state <= S_DECODE;
        end
        S_DECODE: begin
          if (e_note != '0) begin
            bus.note_load  <= 1'b1;
            bus.note_voice <= vptr;
            bus.note_out   <= e_note;
            bus.dur_out    <= e_dur;
            bus.meta_out   <= e_meta;
            vptr           <= next_voice(vptr);
          end
          // An advancing entry closes the chord: the next chord starts on voice 0.
          if (e_adv) begin
            cnt   <= e_dur;
            vptr  <= '0;
            state <= S_WAIT;
          end else begin
            song_done <= LOOP_EN && at_last;
            state     <= S_NEXT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            song_done <= LOOP_EN && at_last;
            state     <= S_NEXT;
          end else if (beat && play) begin
            cnt <= cnt - 1'b1;
          end
        end
        S_NEXT: begin
          if (at_last) begin
            if (LOOP_EN) begin
              index        <= '0;
              bus.rom_addr <= {song_l, {ENTRY_BITS{1'b0}}};
              state        <= S_FETCH;
            end else begin
              song_done <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            index        <= index_nx;
            bus.rom_addr <= {song_l, index_nx};
            state        <= S_FETCH;
          end
        end
        S_DONE: begin
          armed <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
